// File: rtl/i2c_slave_mem_rw.sv
// I2C target that bridges the bus to an on-chip byte memory.
// The master sets a 1..4 byte register pointer, then writes data bytes or
// issues a repeated START and reads bytes back. The pointer auto-increments
// and wraps. SCL/SDA are resynchronised into in_clk before edge detection.
//
// Memory port: out_mem_wr_en / out_mem_rd_en are single-cycle strobes with no
// back-pressure. out_mem_addr is valid in the strobe cycle. For writes,
// out_mem_wr_data is valid in the same cycle. For reads, in_mem_data must be
// valid in the cycle after the strobe. The two strobes are mutually exclusive.
module i2c_slave_mem_rw #(
    parameter logic [6:0] DEV_ADDR               = 7'h50,
    parameter int         MEM_ADDR_WIDTH         = 16,
    parameter int         SYNC_STAGES            = 2,
    parameter int         SDA_SETUP_DELAY_CYCLES = 3
) (
    input  logic                      in_clk,
    input  logic                      in_rst_n,
    input  logic                      in_scl,
    inout  wire                       io_sda,
    output logic                      out_sda_oe,
    output logic [MEM_ADDR_WIDTH-1:0] out_mem_addr,
    output logic [7:0]                out_mem_wr_data,
    output logic                      out_mem_wr_en,
    output logic                      out_mem_rd_en,
    input  logic [7:0]                in_mem_data,
    output logic                      out_busy,
    output logic                      out_stop_pulse,
    output logic [3:0]                out_dbg_state
);

    localparam int ADDR_BYTES = MEM_ADDR_WIDTH / 8;
    localparam int IDX_W      = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int CNT_W      = (SDA_SETUP_DELAY_CYCLES < 2) ? 1 : $clog2(SDA_SETUP_DELAY_CYCLES + 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEV_ADDR = 4'd1,
        ST_ACK_DEV  = 4'd2,
        ST_REG_ADDR = 4'd3,
        ST_ACK_REG  = 4'd4,
        ST_WR_DATA  = 4'd5,
        ST_ACK_WR   = 4'd6,
        ST_RD_LOAD  = 4'd7,
        ST_RD_DATA  = 4'd8,
        ST_RD_ACK   = 4'd9,
        ST_IGNORE   = 4'd10
    } state_e;

    // Synchroniser chains and previous synced values for edge detection.
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    // Protocol state.
    state_e                    state_q, state_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [6:0]                rx_shift_q, rx_shift_d;
    logic [7:0]                rx_byte;
    logic                      rw_q, rw_d;
    logic [IDX_W-1:0]          byte_idx_q, byte_idx_d;
    logic [MEM_ADDR_WIDTH-1:0] shadow_q, shadow_d;
    logic [MEM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [7:0]                tx_shift_q, tx_shift_d;
    logic                      wr_en_q, wr_en_d;
    logic [7:0]                wr_data_q, wr_data_d;
    logic                      rd_en_q, rd_en_d;
    logic                      rd_wait_q, rd_wait_d;
    logic                      busy_q, busy_d;
    logic                      stop_pulse_q, stop_pulse_d;

    // SDA drive scheduling.
    logic             drive_target;
    logic             oe_q, oe_d;
    logic             pend_q, pend_d;
    logic             pend_val_q, pend_val_d;
    logic [CNT_W-1:0] dly_cnt_q, dly_cnt_d;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {rx_shift_q, sda_s};

    // Resynchronise the bus lines; idle-high after reset so no false edge is seen.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], in_scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], io_sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // Protocol FSM next state: transitions happen on synced SCL rise, START/STOP override.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        rw_d         = rw_q;
        byte_idx_d   = byte_idx_q;
        shadow_d     = shadow_q;
        ptr_d        = ptr_q;
        tx_shift_d   = tx_shift_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        rd_en_d      = 1'b0;
        rd_wait_d    = 1'b0;
        busy_d       = busy_q;
        stop_pulse_d = 1'b0;

        // The write strobe cycle presents the old pointer; advance it afterwards.
        if (wr_en_q) begin
            ptr_d = ptr_q + 1'b1;
        end

        if (start_det) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = 3'd0;
        end else if (stop_det) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = 3'd0;
            busy_d       = 1'b0;
            stop_pulse_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_DEV_ADDR: begin
                    if (scl_rise) begin
                        rx_shift_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_d = ST_ACK_DEV;
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                            end else begin
                                state_d = ST_IGNORE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ST_ACK_DEV: begin
                    if (scl_rise) begin
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            state_d = ST_RD_LOAD;
                            rd_en_d = 1'b1;
                        end else begin
                            state_d    = ST_REG_ADDR;
                            byte_idx_d = '0;
                        end
                    end
                end
                ST_REG_ADDR: begin
                    if (scl_rise) begin
                        rx_shift_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            // First address byte on the wire is the most significant.
                            for (int b = 0; b < ADDR_BYTES; b++) begin
                                if (int'(byte_idx_q) == ADDR_BYTES - 1 - b) begin
                                    shadow_d[b*8 +: 8] = rx_byte;
                                end
                            end
                            state_d = ST_ACK_REG;
                        end
                    end
                end
                ST_ACK_REG: begin
                    if (scl_rise) begin
                        bit_cnt_d = 3'd0;
                        if (int'(byte_idx_q) == ADDR_BYTES - 1) begin
                            ptr_d   = shadow_q;
                            state_d = ST_WR_DATA;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                            state_d    = ST_REG_ADDR;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        rx_shift_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = rx_byte;
                            state_d   = ST_ACK_WR;
                        end
                    end
                end
                ST_ACK_WR: begin
                    if (scl_rise) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ST_WR_DATA;
                    end
                end
                ST_RD_LOAD: begin
                    // Strobe cycle, then one cycle later capture the returned byte.
                    if (rd_en_q) begin
                        rd_wait_d = 1'b1;
                    end else if (rd_wait_q) begin
                        tx_shift_d = in_mem_data;
                        ptr_d      = ptr_q + 1'b1;
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_RD_ACK;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = 3'd0;
                        if (!sda_s) begin
                            state_d = ST_RD_LOAD;
                            rd_en_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_IGNORE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // SDA drive: the value for the next bit is chosen at SCL fall and applied after the setup delay.
    always_comb begin
        case (state_q)
            ST_ACK_DEV, ST_ACK_REG, ST_ACK_WR: drive_target = 1'b1;
            ST_RD_DATA:                        drive_target = ~tx_shift_q[7];
            default:                           drive_target = 1'b0;
        endcase

        oe_d       = oe_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        dly_cnt_d  = dly_cnt_q;

        if (start_det || stop_det) begin
            oe_d   = 1'b0;
            pend_d = 1'b0;
        end else if (scl_fall) begin
            if (SDA_SETUP_DELAY_CYCLES == 0) begin
                oe_d   = drive_target;
                pend_d = 1'b0;
            end else begin
                pend_d     = 1'b1;
                pend_val_d = drive_target;
                dly_cnt_d  = CNT_W'(SDA_SETUP_DELAY_CYCLES);
            end
        end else if (pend_q) begin
            // A rising SCL forces any late change through so the sampled bit is defined.
            if (scl_rise || (dly_cnt_q <= CNT_W'(1))) begin
                oe_d   = pend_val_q;
                pend_d = 1'b0;
            end else begin
                dly_cnt_d = dly_cnt_q - 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= '0;
            rw_q         <= 1'b0;
            byte_idx_q   <= '0;
            shadow_q     <= '0;
            ptr_q        <= '0;
            tx_shift_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            rd_en_q      <= 1'b0;
            rd_wait_q    <= 1'b0;
            busy_q       <= 1'b0;
            stop_pulse_q <= 1'b0;
            oe_q         <= 1'b0;
            pend_q       <= 1'b0;
            pend_val_q   <= 1'b0;
            dly_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rw_q         <= rw_d;
            byte_idx_q   <= byte_idx_d;
            shadow_q     <= shadow_d;
            ptr_q        <= ptr_d;
            tx_shift_q   <= tx_shift_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            rd_en_q      <= rd_en_d;
            rd_wait_q    <= rd_wait_d;
            busy_q       <= busy_d;
            stop_pulse_q <= stop_pulse_d;
            oe_q         <= oe_d;
            pend_q       <= pend_d;
            pend_val_q   <= pend_val_d;
            dly_cnt_q    <= dly_cnt_d;
        end
    end

    assign io_sda          = oe_q ? 1'b0 : 1'bz;
    assign out_sda_oe      = oe_q;
    assign out_mem_addr    = ptr_q;
    assign out_mem_wr_data = wr_data_q;
    assign out_mem_wr_en   = wr_en_q;
    assign out_mem_rd_en   = rd_en_q;
    assign out_busy        = busy_q;
    assign out_stop_pulse  = stop_pulse_q;
    assign out_dbg_state   = state_q;

endmodule

// File: tb/tb_i2c_slave_mem_rw.sv
// Bench for i2c_slave_mem_rw: bit-banged I2C master, byte memory model with
// registered read data, and scoreboard queues for memory strobes and read bytes.
module tb_i2c_slave_mem_rw;

    localparam int HALF = 20;
    localparam int QTR  = 10;
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_IGNORE = 4'd10;

    // Clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Bus: open-drain master side plus pull-up
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    wire  sda_w;
    assign sda_w = m_sda ? 1'bz : 1'b0;
    pullup (sda_w);

    logic        sda_oe;
    logic [15:0] mem_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  mem_data;
    logic        busy;
    logic        stop_pulse;
    logic [3:0]  dbg_state;

    i2c_slave_mem_rw dut (
        .in_clk          (clk),
        .in_rst_n        (rst_n),
        .in_scl          (m_scl),
        .io_sda          (sda_w),
        .out_sda_oe      (sda_oe),
        .out_mem_addr    (mem_addr),
        .out_mem_wr_data (wr_data),
        .out_mem_wr_en   (wr_en),
        .out_mem_rd_en   (rd_en),
        .in_mem_data     (mem_data),
        .out_busy        (busy),
        .out_stop_pulse  (stop_pulse),
        .out_dbg_state   (dbg_state)
    );

    // Memory model: mem[i] = i[7:0] ^ 8'h5A, data returned the cycle after the strobe
    always @(posedge clk) begin
        if (!rst_n) mem_data <= 8'h00;
        else if (rd_en) mem_data <= mem_addr[7:0] ^ 8'h5A;
    end

    // Scoreboard
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] wr_exp_q[$];
    logic [15:0] rd_exp_q[$];
    logic [7:0]  rdb_exp_q[$];
    int          stop_cnt = 0;
    logic        oe_seen  = 1'b0;
    logic        busy_seen = 1'b0;

    // Strobe monitor
    always @(negedge clk) begin
        logic [23:0] wexp;
        logic [15:0] rexp;
        if (rst_n) begin
            if (sda_oe) oe_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (stop_pulse) stop_cnt++;
            if (wr_en || rd_en) begin
                n_checks++;
                if ((wr_en && rd_en) || dbg_state == ST_IDLE || dbg_state == ST_IGNORE) begin
                    n_fail++;
                    $display("FAIL strobe_legal: wr_en=%b rd_en=%b state=%0d, want single strobe outside IDLE/IGNORE", wr_en, rd_en, dbg_state);
                end
            end
            if (wr_en) begin
                n_checks++;
                if (wr_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_strobe: got addr=%h data=%h, want no write", mem_addr, wr_data);
                end else begin
                    wexp = wr_exp_q.pop_front();
                    if ({mem_addr, wr_data} !== wexp) begin
                        n_fail++;
                        $display("FAIL wr_strobe: got addr=%h data=%h, want addr=%h data=%h", mem_addr, wr_data, wexp[23:8], wexp[7:0]);
                    end
                end
            end
            if (rd_en) begin
                n_checks++;
                if (rd_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_strobe: got addr=%h, want no read", mem_addr);
                end else begin
                    rexp = rd_exp_q.pop_front();
                    if (mem_addr !== rexp) begin
                        n_fail++;
                        $display("FAIL rd_strobe: got addr=%h, want addr=%h", mem_addr, rexp);
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clks(QTR);
        m_scl = 1'b1; wait_clks(HALF);
        m_sda = 1'b0; wait_clks(HALF);
        m_scl = 1'b0; wait_clks(2);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clks(QTR);
        m_scl = 1'b1; wait_clks(HALF);
        m_sda = 1'b1; wait_clks(HALF);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        m_sda = b;    wait_clks(HALF);
        m_scl = 1'b1; wait_clks(HALF / 2);
        r = sda_w;    wait_clks(HALF / 2);
        m_scl = 1'b0; wait_clks(2);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, r);
            d = {d[6:0], r};
        end
        bit_xfer(nack, r);
    endtask

    // Tests
    task automatic test_reset();
        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
        wait_clks(4);
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", sda_oe); end
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        n_checks++; if ({wr_en, rd_en, busy, stop_pulse} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {wr_en, rd_en, busy, stop_pulse}); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_checks++; if (sda_w !== 1'b1) begin n_fail++; $display("FAIL reset_bus: got %b want 1 (released)", sda_w); end
        rst_n = 1'b1;
        wait_clks(5);
        stop_cnt = 0; oe_seen = 1'b0;
        m_scl = 1'b0; wait_clks(QTR);
        m_sda = 1'b0; wait_clks(QTR);
        m_scl = 1'b1; wait_clks(HALF);
        m_sda = 1'b1; wait_clks(HALF);
        n_checks++; if (stop_cnt !== 1) begin n_fail++; $display("FAIL lone_stop_pulse: got %0d want 1", stop_cnt); end
        n_checks++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL lone_stop_drive: got %b want 0", oe_seen); end
    endtask

    task automatic test_write();
        logic [7:0] seq[5];
        logic ack;
        seq = '{8'hA0, 8'h12, 8'h34, 8'hDE, 8'hAD};
        stop_cnt = 0; busy_seen = 1'b0;
        wr_exp_q.push_back({16'h1234, 8'hDE});
        wr_exp_q.push_back({16'h1235, 8'hAD});
        i2c_start();
        for (int i = 0; i < 5; i++) begin
            write_byte(seq[i], ack);
            n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL write_ack[%0d]: got %b want 0", i, ack); end
        end
        i2c_stop();
        wait_clks(4);
        n_checks++; if (mem_addr !== 16'h1236) begin n_fail++; $display("FAIL write_ptr: got %h want 1236", mem_addr); end
        n_checks++; if (busy_seen !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL write_busy: seen=%b now=%b want 1/0", busy_seen, busy); end
        n_checks++; if (stop_cnt !== 1) begin n_fail++; $display("FAIL write_stop_pulse: got %0d want 1", stop_cnt); end
        n_checks++; if (wr_exp_q.size() !== 0) begin n_fail++; $display("FAIL write_pending: got %0d want 0", wr_exp_q.size()); end
    endtask

    task automatic test_read();
        logic [7:0] seq[3];
        logic [7:0] d;
        logic [7:0] e;
        logic ack;
        seq = '{8'hA0, 8'h00, 8'h10};
        for (int i = 0; i < 3; i++) begin
            rd_exp_q.push_back(16'h0010 + 16'(i));
            rdb_exp_q.push_back(8'(8'h10 + i) ^ 8'h5A);
        end
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            write_byte(seq[i], ack);
            n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL read_setup_ack[%0d]: got %b want 0", i, ack); end
        end
        i2c_start();
        write_byte(8'hA1, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL read_dev_ack: got %b want 0", ack); end
        for (int i = 0; i < 3; i++) begin
            read_byte(i == 2, d);
            e = rdb_exp_q.pop_front();
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL read_byte[%0d]: got %h want %h", i, d, e); end
        end
        i2c_stop();
        wait_clks(4);
        n_checks++; if (mem_addr !== 16'h0013) begin n_fail++; $display("FAIL read_ptr: got %h want 0013", mem_addr); end
        n_checks++; if (rd_exp_q.size() !== 0) begin n_fail++; $display("FAIL read_pending: got %0d want 0", rd_exp_q.size()); end
    endtask

    task automatic test_foreign();
        logic ack;
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        write_byte(8'hA2, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL foreign_nack: got %b want 1", ack); end
        write_byte(8'h55, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL foreign_data_nack: got %b want 1", ack); end
        n_checks++; if (dbg_state !== ST_IGNORE) begin n_fail++; $display("FAIL foreign_state: got %0d want %0d", dbg_state, ST_IGNORE); end
        i2c_stop();
        wait_clks(4);
        n_checks++; if (oe_seen !== 1'b0 || busy_seen !== 1'b0) begin n_fail++; $display("FAIL foreign_quiet: oe_seen=%b busy_seen=%b want 0/0", oe_seen, busy_seen); end
        n_checks++; if (mem_addr !== 16'h0013) begin n_fail++; $display("FAIL foreign_ptr: got %h want 0013", mem_addr); end
    endtask

    task automatic test_wrap();
        logic [7:0] seq[5];
        logic ack;
        seq = '{8'hA0, 8'hFF, 8'hFF, 8'h11, 8'h22};
        wr_exp_q.push_back({16'hFFFF, 8'h11});
        wr_exp_q.push_back({16'h0000, 8'h22});
        i2c_start();
        for (int i = 0; i < 5; i++) begin
            write_byte(seq[i], ack);
            n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wrap_ack[%0d]: got %b want 0", i, ack); end
        end
        i2c_stop();
        wait_clks(4);
        n_checks++; if (mem_addr !== 16'h0001) begin n_fail++; $display("FAIL wrap_ptr: got %h want 0001", mem_addr); end
        n_checks++; if (wr_exp_q.size() !== 0) begin n_fail++; $display("FAIL wrap_pending: got %0d want 0", wr_exp_q.size()); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] seq[4];
        logic ack;
        seq = '{8'hA0, 8'h00, 8'h20, 8'h00};
        rd_exp_q.push_back(16'h0020);
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            write_byte(seq[i], ack);
            n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mid_setup_ack[%0d]: got %b want 0", i, ack); end
        end
        i2c_start();
        write_byte(8'hA1, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mid_dev_ack: got %b want 0", ack); end
        // mem[0x20] = 0x7A, MSB 0: target is pulling SDA low for the first data bit
        wait_clks(12);
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL mid_drive: got %b want 1", sda_oe); end
        rst_n = 1'b0;
        wait_clks(1);
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL mid_reset_oe: got %b want 0", sda_oe); end
        n_checks++; if (dbg_state !== ST_IDLE || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_state: state=%0d ptr=%h want %0d/0000", dbg_state, mem_addr, ST_IDLE); end
        rst_n = 1'b1;
        wait_clks(4);
        seq = '{8'hA0, 8'h00, 8'h05, 8'h77};
        wr_exp_q.push_back({16'h0005, 8'h77});
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(seq[i], ack);
            n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL post_reset_ack[%0d]: got %b want 0", i, ack); end
        end
        i2c_stop();
        wait_clks(4);
        n_checks++; if (mem_addr !== 16'h0006) begin n_fail++; $display("FAIL post_reset_ptr: got %h want 0006", mem_addr); end
        n_checks++; if (wr_exp_q.size() !== 0 || rd_exp_q.size() !== 0) begin n_fail++; $display("FAIL post_reset_pending: wr=%0d rd=%0d want 0/0", wr_exp_q.size(), rd_exp_q.size()); end
    endtask

    // Sequence and report
    initial begin
        test_reset();
        test_write();
        test_read();
        test_foreign();
        test_wrap();
        test_reset_mid_read();
        wait_clks(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
